// File: rtl/smi_self_link_fifo_buffer_if.sv
// -----------------------------------------------------------------------------
// smi_self_link_fifo_buffer_if
// Bundles the SELF handshake signals of the multi-entry link buffer.
//
// Signals:
//   dataInValid  upstream token valid
//   dataIn       upstream token data
//   dataInStop   upstream stop (driven by the buffer)
//   dataOutValid downstream token valid (driven by the buffer)
//   dataOut      downstream token data (driven by the buffer)
//   dataOutStop  downstream stop
//   fillLevel    buffer occupancy (driven by the buffer)
//   almostFull   occupancy threshold flag (driven by the buffer)
//
// Modports:
//   slave  - the buffer's view
//   master - the surrounding environment's view
// -----------------------------------------------------------------------------
interface smi_self_link_fifo_buffer_if #(
   parameter int DataWidth  = 16,
   parameter int LevelWidth = 3
);
   logic                  dataInValid;
   logic [DataWidth-1:0]  dataIn;
   logic                  dataInStop;
   logic                  dataOutValid;
   logic [DataWidth-1:0]  dataOut;
   logic                  dataOutStop;
   logic [LevelWidth-1:0] fillLevel;
   logic                  almostFull;

   modport slave (
      input  dataInValid, dataIn, dataOutStop,
      output dataInStop, dataOutValid, dataOut, fillLevel, almostFull
   );

   modport master (
      output dataInValid, dataIn, dataOutStop,
      input  dataInStop, dataOutValid, dataOut, fillLevel, almostFull
   );
endinterface

// File: rtl/smi_self_link_fifo_buffer.sv
// -----------------------------------------------------------------------------
// smi_self_link_fifo_buffer
// Multi-entry SELF elastic buffer for SMI links. Both flow-control outputs
// come straight from flops, and one token per cycle is sustained when
// Depth >= 2. The buffer also reports its occupancy and an almost-full flag.
//
// Parameters:
//   DataWidth       token width
//   Depth           number of storage entries (1..256, any integer)
//   LevelWidth      fillLevel width, 2**LevelWidth > Depth
//   AlmostFullLevel occupancy at or above which almostFull asserts
//
// Ports:
//   clk     system clock, rising edge
//   srst_n  synchronous active-low reset
//   link    handshake bundle (slave view): dataIn*/dataOut* SELF channels,
//           fillLevel and almostFull
// -----------------------------------------------------------------------------
module smi_self_link_fifo_buffer #(
   parameter int DataWidth       = 16,
   parameter int Depth           = 4,
   parameter int LevelWidth      = 3,
   parameter int AlmostFullLevel = 3
) (
   input logic                        clk,
   input logic                        srst_n,
   smi_self_link_fifo_buffer_if.slave link
);

   localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   localparam logic [PtrWidth-1:0]   LastPtr  = PtrWidth'(Depth - 1);
   localparam logic [LevelWidth-1:0] FullCnt  = LevelWidth'(Depth);
   localparam logic [LevelWidth-1:0] AfullCnt = LevelWidth'(AlmostFullLevel);

   // Storage array, deliberately left without reset.
   logic [DataWidth-1:0]  mem [Depth];

   logic [PtrWidth-1:0]   wp;
   logic [PtrWidth-1:0]   rp;
   logic [LevelWidth-1:0] count;

   logic                  inStop;
   logic                  outValid;
   logic [LevelWidth-1:0] level;
   logic                  afull;

   logic                  push;
   logic                  pop;
   logic [PtrWidth-1:0]   wpNext;
   logic [PtrWidth-1:0]   rpNext;
   logic [LevelWidth-1:0] countNext;

   // Transfers use the registered flow-control state, never the raw inputs.
   assign push = link.dataInValid & ~inStop;
   assign pop  = outValid & ~link.dataOutStop;

   // Next occupancy from the push/pop pair.
   always_comb begin
      countNext = count;
      case ({push, pop})
         2'b10:   countNext = count + LevelWidth'(1);
         2'b01:   countNext = count - LevelWidth'(1);
         default: countNext = count;
      endcase
   end

   // Next pointers; the wrap is an explicit compare so Depth need not be 2**n.
   always_comb begin
      wpNext = wp;
      rpNext = rp;
      if (push) begin
         if (wp == LastPtr) begin
            wpNext = '0;
         end else begin
            wpNext = wp + PtrWidth'(1);
         end
      end else begin
         wpNext = wp;
      end
      if (pop) begin
         if (rp == LastPtr) begin
            rpNext = '0;
         end else begin
            rpNext = rp + PtrWidth'(1);
         end
      end else begin
         rpNext = rp;
      end
   end

   // Pointer, occupancy and registered status update.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         inStop   <= 1'b1;   // SELF startup: stop upstream until out of reset
         outValid <= 1'b0;
         level    <= '0;
         afull    <= 1'b0;
      end else begin
         wp       <= wpNext;
         rp       <= rpNext;
         count    <= countNext;
         inStop   <= (countNext == FullCnt);
         outValid <= (countNext != '0);
         level    <= countNext;
         afull    <= (countNext >= AfullCnt);
      end
   end

   // Data capture into the entry addressed by the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= link.dataIn;
      end
   end

   // The head entry is stable while stopped because rp only moves on pop.
   assign link.dataOut      = mem[rp];
   assign link.dataInStop   = inStop;
   assign link.dataOutValid = outValid;
   assign link.fillLevel    = level;
   assign link.almostFull   = afull;

endmodule

// File: tb/tb_smi_self_link_fifo_buffer.sv
// -----------------------------------------------------------------------------
// tb_smi_self_link_fifo_buffer
// Directed bench for smi_self_link_fifo_buffer with three instances:
//   dutA  Depth=4, AlmostFullLevel=3  (startup, streaming, fill/release)
//   dutB  Depth=3                     (wrap-around against a queue model)
//   dutC  Depth=1                     (half-rate throughput, mid-run reset)
// -----------------------------------------------------------------------------
module tb_smi_self_link_fifo_buffer;

   logic clk;
   logic srst_n;

   int checks   = 0;
   int failures = 0;

   smi_self_link_fifo_buffer_if #(.DataWidth(16), .LevelWidth(3)) busA ();
   smi_self_link_fifo_buffer_if #(.DataWidth(16), .LevelWidth(2)) busB ();
   smi_self_link_fifo_buffer_if #(.DataWidth(16), .LevelWidth(2)) busC ();

   smi_self_link_fifo_buffer #(
      .DataWidth(16), .Depth(4), .LevelWidth(3), .AlmostFullLevel(3)
   ) dutA (
      .clk(clk), .srst_n(srst_n), .link(busA.slave)
   );

   smi_self_link_fifo_buffer #(
      .DataWidth(16), .Depth(3), .LevelWidth(2), .AlmostFullLevel(2)
   ) dutB (
      .clk(clk), .srst_n(srst_n), .link(busB.slave)
   );

   smi_self_link_fifo_buffer #(
      .DataWidth(16), .Depth(1), .LevelWidth(2), .AlmostFullLevel(1)
   ) dutC (
      .clk(clk), .srst_n(srst_n), .link(busC.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare the full status of dutA; data only matters while valid.
   task automatic expA(input string tag, input logic v, input logic [15:0] d,
                       input logic s, input int lvl, input logic af);
      checkEq({tag, "_valid"}, 32'(busA.dataOutValid), 32'(v));
      if (v) begin
         checkEq({tag, "_data"}, 32'(busA.dataOut), 32'(d));
      end
      checkEq({tag, "_stop"}, 32'(busA.dataInStop), 32'(s));
      checkEq({tag, "_level"}, 32'(busA.fillLevel), 32'(lvl));
      checkEq({tag, "_afull"}, 32'(busA.almostFull), 32'(af));
   endtask

   initial begin
      logic [15:0] q[$];
      logic        offerValid;
      logic [15:0] offerData;
      logic        mpush;
      logic        mpop;
      int          sent;
      int          recv;
      int          cyc;

      srst_n = 1'b0;
      busA.dataInValid = 1'b0; busA.dataIn = 16'h0000; busA.dataOutStop = 1'b0;
      busB.dataInValid = 1'b0; busB.dataIn = 16'h0000; busB.dataOutStop = 1'b0;
      busC.dataInValid = 1'b0; busC.dataIn = 16'h0000; busC.dataOutStop = 1'b0;

      // ---------------- reset / startup ----------------
      for (int i = 0; i < 3; i++) begin
         step();
         checkEq("rst_stop", 32'(busA.dataInStop), 32'd1);
         checkEq("rst_valid", 32'(busA.dataOutValid), 32'd0);
      end
      checkEq("rst_level", 32'(busA.fillLevel), 32'd0);
      checkEq("rst_afull", 32'(busA.almostFull), 32'd0);
      srst_n = 1'b1;
      #1;
      checkEq("rel_stop_hold", 32'(busA.dataInStop), 32'd1);
      step();
      expA("rel", 1'b0, 16'h0000, 1'b0, 0, 1'b0);
      checkEq("relB_stop", 32'(busB.dataInStop), 32'd0);
      checkEq("relC_stop", 32'(busC.dataInStop), 32'd0);

      // ---------------- streaming, Depth=4 ----------------
      for (int i = 1; i <= 16; i++) begin
         busA.dataInValid = 1'b1;
         busA.dataIn      = 16'(i);
         step();
         checkEq("str_valid", 32'(busA.dataOutValid), 32'd1);
         checkEq("str_data", 32'(busA.dataOut), 32'(i));
         checkEq("str_stop", 32'(busA.dataInStop), 32'd0);
         checkEq("str_level", 32'(busA.fillLevel), 32'd1);
      end
      busA.dataInValid = 1'b0;
      step();
      expA("str_end", 1'b0, 16'h0000, 1'b0, 0, 1'b0);

      // ---------------- fill / backpressure ----------------
      busA.dataOutStop = 1'b1;
      busA.dataInValid = 1'b1;
      busA.dataIn = 16'hAAAA; step(); expA("fill_a", 1'b1, 16'hAAAA, 1'b0, 1, 1'b0);
      busA.dataIn = 16'hBBBB; step(); expA("fill_b", 1'b1, 16'hAAAA, 1'b0, 2, 1'b0);
      busA.dataIn = 16'hCCCC; step(); expA("fill_c", 1'b1, 16'hAAAA, 1'b0, 3, 1'b1);
      busA.dataIn = 16'hDDDD; step(); expA("fill_d", 1'b1, 16'hAAAA, 1'b1, 4, 1'b1);
      busA.dataIn = 16'hEEEE; step(); expA("fill_e1", 1'b1, 16'hAAAA, 1'b1, 4, 1'b1);
      step();                         expA("fill_e2", 1'b1, 16'hAAAA, 1'b1, 4, 1'b1);

      // ---------------- release from full ----------------
      busA.dataOutStop = 1'b0;        // E still offered, must not enter
      step();                         expA("rel_popA", 1'b1, 16'hBBBB, 1'b0, 3, 1'b1);
      busA.dataOutStop = 1'b1;        // E now accepted
      step();                         expA("rel_pushE", 1'b1, 16'hBBBB, 1'b1, 4, 1'b1);
      busA.dataIn = 16'hFFFF;
      step();                         expA("rel_blockF", 1'b1, 16'hBBBB, 1'b1, 4, 1'b1);
      busA.dataInValid = 1'b0;
      busA.dataOutStop = 1'b0;
      step();                         expA("drain_b", 1'b1, 16'hCCCC, 1'b0, 3, 1'b1);
      step();                         expA("drain_c", 1'b1, 16'hDDDD, 1'b0, 2, 1'b0);
      step();                         expA("drain_d", 1'b1, 16'hEEEE, 1'b0, 1, 1'b0);
      step();                         expA("drain_e", 1'b0, 16'h0000, 1'b0, 0, 1'b0);

      // ---------------- wrap-around, Depth=3 ----------------
      offerValid = 1'b0;
      offerData  = 16'h0000;
      sent = 0;
      recv = 0;
      cyc  = 0;
      while (recv < 1000 && cyc < 20000) begin
         if (!offerValid && sent < 1000 && $urandom_range(0, 1) == 1) begin
            offerValid = 1'b1;
            offerData  = 16'($urandom_range(0, 65535));
         end
         busB.dataInValid = offerValid;
         busB.dataIn      = offerData;
         busB.dataOutStop = 1'($urandom_range(0, 1));
         mpush = offerValid && (q.size() != 3);
         mpop  = (q.size() != 0) && !busB.dataOutStop;
         if (mpop) begin
            checkEq("rnd_data", 32'(busB.dataOut), 32'(q[0]));
         end
         step();
         if (mpop) begin
            void'(q.pop_front());
            recv++;
         end
         if (mpush) begin
            q.push_back(offerData);
            sent++;
            offerValid = 1'b0;
         end
         checkEq("rnd_level", 32'(busB.fillLevel), 32'(q.size()));
         checkEq("rnd_valid", 32'(busB.dataOutValid), 32'(q.size() != 0));
         checkEq("rnd_stop", 32'(busB.dataInStop), 32'(q.size() == 3));
         cyc++;
      end
      checkEq("rnd_done", 32'(recv), 32'd1000);
      busB.dataInValid = 1'b0;
      busB.dataOutStop = 1'b0;

      // ---------------- Depth=1 half rate ----------------
      busC.dataInValid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         busC.dataIn = 16'(16'h1100 + i);
         step();
         checkEq("d1_valid_on", 32'(busC.dataOutValid), 32'd1);
         checkEq("d1_data", 32'(busC.dataOut), 32'(16'h1100 + i));
         checkEq("d1_stop_on", 32'(busC.dataInStop), 32'd1);
         busC.dataIn = 16'(16'h1100 + i + 1);
         step();
         checkEq("d1_valid_off", 32'(busC.dataOutValid), 32'd0);
         checkEq("d1_stop_off", 32'(busC.dataInStop), 32'd0);
      end

      // ---------------- mid-run reset with a held token ----------------
      busC.dataIn      = 16'h7777;
      busC.dataOutStop = 1'b1;
      step();
      checkEq("mr_held", 32'(busC.dataOutValid), 32'd1);
      busC.dataInValid = 1'b0;
      srst_n = 1'b0;
      step();
      checkEq("mr_valid", 32'(busC.dataOutValid), 32'd0);
      checkEq("mr_stop", 32'(busC.dataInStop), 32'd1);
      checkEq("mr_level", 32'(busC.fillLevel), 32'd0);
      srst_n = 1'b1;
      busC.dataOutStop = 1'b0;
      step();
      checkEq("mr_rel_stop", 32'(busC.dataInStop), 32'd0);
      checkEq("mr_rel_valid", 32'(busC.dataOutValid), 32'd0);
      step();
      checkEq("mr_no_stale", 32'(busC.dataOutValid), 32'd0);
      busC.dataInValid = 1'b1;
      busC.dataIn      = 16'h5A5A;
      step();
      checkEq("mr_new_valid", 32'(busC.dataOutValid), 32'd1);
      checkEq("mr_new_data", 32'(busC.dataOut), 32'h5A5A);
      busC.dataInValid = 1'b0;
      step();
      checkEq("mr_new_drain", 32'(busC.dataOutValid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
